mac_seq: RTL and testbench
==========================

MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter: CNT_W, 5, width of the MAC counter bus.
REQ-002 Parameter: SUM_W, 20, width of the MAC sum bus.
REQ-003 Parameter: NTAPS, 16, maximum taps per run; the drain code equals NTAPS.
REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  request a dot-product run; sampled only in IDLE.
REQ-007 Port: len  input  CNT_W  taps for the run; latched when start is accepted.
REQ-008 Port: cnt  output  CNT_W  registered counter driven to the downstream MAC.
REQ-009 Port: sum_in  input  SUM_W  accumulated sum returned by the MAC.
REQ-010 Port: result  output  SUM_W  captured dot-product result; holds its value until the next capture.
REQ-011 Port: busy  output  1  registered; high in RUN, DRAIN and CAPTURE.
REQ-012 Port: done  output  1  registered one-cycle pulse marking a new result.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, DRAIN and CAPTURE.
REQ-014 In IDLE, cnt SHALL be 0; this holds the MAC accumulator cleared with tap 0 preloaded.
REQ-015 The effective length L SHALL be computed from len at start acceptance: len=0 gives 16, len>16 gives 16, otherwise len.
REQ-016 IDLE with start=1 SHALL latch L, set busy=1 and go to RUN with cnt=1 if L>1, or to DRAIN with cnt=16 if L=1.
REQ-017 RUN SHALL increment cnt by 1 per cycle; after cnt=L-1 the next cycle SHALL be DRAIN with cnt=16.
REQ-018 DRAIN SHALL last exactly 1 cycle with cnt=16, then go to CAPTURE with cnt held at 16.
REQ-019 At the edge ending CAPTURE: result<=sum_in, done<=1, busy<=0, cnt<=0, and the state returns to IDLE.
REQ-020 done SHALL be high for exactly one cycle: the first IDLE cycle after CAPTURE.
REQ-021 Latency: if start is sampled at edge E0, done and result SHALL be valid after edge E(L+1).
REQ-022 cnt SHALL never take values in L..15 during a run; the sequence is 0, 1..L-1, 16, 16, 0.
REQ-023 start while busy=1 SHALL be ignored, and len SHALL NOT be re-latched.
REQ-024 start high in the done cycle SHALL be accepted, giving back-to-back runs with no idle gap.
REQ-025 result SHALL be SUM_W bits with no truncation; the worst case is 16*255*255=1040400, which is below 2^20.
REQ-026 result SHALL change only at the CAPTURE edge or on reset.

Reset
REQ-027 While rst=1 at a clock edge: state=IDLE, cnt=0, result=0, busy=0, done=0, latched L=16.
REQ-028 rst SHALL take priority over start, abort and every state transition.
REQ-029 rst asserted mid-run SHALL abandon the run with no done pulse; result SHALL be 0.

Configuration
REQ-030 When MAC_SEQ_ABORT_EN is defined, the block SHALL add port abort (input, 1 bit).
REQ-031 With MAC_SEQ_ABORT_EN: abort=1 in RUN, DRAIN or CAPTURE SHALL force the state to IDLE with cnt=0 and busy=0 at the next edge.
REQ-032 With MAC_SEQ_ABORT_EN: an aborted run SHALL leave result unchanged and SHALL NOT pulse done; abort in IDLE has no effect.
REQ-033 If abort and start are both high in IDLE, start SHALL win.
REQ-034 Without MAC_SEQ_ABORT_EN, the abort port and its logic SHALL be absent and behaviour SHALL be as in REQ-013 to REQ-029.

Verification
REQ-035 The bench SHALL pair the block with a behavioural MAC model on cnt/sum_in and cover:
REQ-036 Reset, then start with len=16 and all taps 1 -> cnt=1..15,16,16,0; done after edge E17; result=16.
REQ-037 len=1 with m1[0]=m2[0]=255 -> cnt=16,16,0; done after edge E2; result=65025.
REQ-038 len=16 with all taps 255 -> result=1040400 (0xFE010); then len=0 -> identical run, result=1040400.
REQ-039 start pulsed during RUN -> ignored; start in the done cycle -> second run begins, cnt=1 on the next cycle.
REQ-040 rst during RUN at cnt=7 -> cnt=0, busy=0, result=0, no done; with MAC_SEQ_ABORT_EN, abort at cnt=7 -> result keeps its prior value and no done.

Source files
------------

// File: rtl/mac_seq.sv
// Dot-product sequencer: walks a tap counter for a downstream MAC and captures its sum.
// Optional abort input is compiled in when MAC_SEQ_ABORT_EN is defined.
module mac_seq #(
    parameter int CNT_W = 5,
    parameter int SUM_W = 20,
    parameter int NTAPS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] cnt,
    input  logic [SUM_W-1:0] sum_in,
    output logic [SUM_W-1:0] result,
    output logic             busy,
    output logic             done
`ifdef MAC_SEQ_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, CAPTURE} state_t;

    localparam logic [CNT_W-1:0] DRAIN_CODE = CNT_W'(NTAPS);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CNT_W-1:0]   len_reg, len_next;
    logic [SUM_W-1:0]   result_reg, result_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [CNT_W-1:0]   eff_len;

    // Zero and oversize requests both mean a full-length run.
    always_comb begin
        if (len == '0 || len > DRAIN_CODE) begin
            eff_len = DRAIN_CODE;
        end else begin
            eff_len = len;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        len_next    = len_reg;
        result_next = result_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next  = '0;
                busy_next = 1'b0;
                if (start) begin
                    len_next  = eff_len;
                    busy_next = 1'b1;
                    if (eff_len > ONE) begin
                        state_next = RUN;
                        cnt_next   = ONE;
                    end else begin
                        state_next = DRAIN;
                        cnt_next   = DRAIN_CODE;
                    end
                end
            end
            RUN: begin
                if (cnt_reg == len_reg - ONE) begin
                    state_next = DRAIN;
                    cnt_next   = DRAIN_CODE;
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end
            DRAIN: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                result_next = sum_in;
                done_next   = 1'b1;
                busy_next   = 1'b0;
                cnt_next    = '0;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                busy_next  = 1'b0;
            end
        endcase
`ifdef MAC_SEQ_ABORT_EN
        // Abort discards the run entirely, including a pending capture.
        if (abort && state_reg != IDLE) begin
            state_next  = IDLE;
            cnt_next    = '0;
            busy_next   = 1'b0;
            done_next   = 1'b0;
            result_next = result_reg;
            len_next    = len_reg;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            len_reg    <= DRAIN_CODE;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            len_reg    <= len_next;
            result_reg <= result_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign cnt    = cnt_reg;
    assign result = result_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq, paired with a behavioural one-stage MAC on cnt/sum_in.
module tb_mac_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  len;
    logic [4:0]  cnt;
    logic [19:0] sum_in;
    logic [19:0] result;
    logic        busy;
    logic        done;
`ifdef MAC_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [19:0] last_result;

    logic [7:0]  m1 [16];
    logic [7:0]  m2 [16];
    logic [19:0] acc;
    logic [19:0] prod;

    always #5 clk = ~clk;

    mac_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .len    (len),
        .cnt    (cnt),
        .sum_in (sum_in),
        .result (result),
        .busy   (busy),
        .done   (done)
`ifdef MAC_SEQ_ABORT_EN
        ,
        .abort  (abort)
`endif
    );

    // MAC model: cnt=0 clears and preloads tap 0, 1..15 accumulate and fetch, 16 drains.
    always @(posedge clk) begin
        if (cnt == 5'd0) begin
            acc  <= 20'd0;
            prod <= 20'(m1[0]) * 20'(m2[0]);
        end else if (cnt < 5'd16) begin
            acc  <= acc + prod;
            prod <= 20'(m1[cnt[3:0]]) * 20'(m2[cnt[3:0]]);
        end else begin
            acc  <= acc + prod;
            prod <= 20'd0;
        end
    end
    assign sum_in = acc;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 16; i++) begin
            m1[i] = a;
            m2[i] = b;
        end
    endtask

    // Issues start at the current negedge and follows the run to its done cycle.
    task automatic run_check(input int len_in, input int eff, input logic [19:0] exp_res,
                             input bit poke, input string tag);
        start = 1'b1;
        len   = 5'(len_in);
        tick();
        start = 1'b0;
        len   = 5'd3;
        for (int i = 0; i <= eff; i++) begin
            chk({tag, "_cnt"}, 32'(cnt), (i < eff - 1) ? 32'(i + 1) : 32'd16);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_done"}, 32'(done), 32'd0);
            chk({tag, "_hold"}, 32'(result), 32'(last_result));
            if (poke && i == 3) begin
                start = 1'b1;
                len   = 5'd2;
            end else begin
                start = 1'b0;
                len   = 5'd3;
            end
            tick();
        end
        start = 1'b0;
        chk({tag, "_end_cnt"}, 32'(cnt), 32'd0);
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
        chk({tag, "_end_done"}, 32'(done), 32'd1);
        chk({tag, "_result"}, 32'(result), 32'(exp_res));
        last_result = exp_res;
    endtask

    task automatic idle_check(input string tag);
        tick();
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_cnt"}, 32'(cnt), 32'd0);
        chk({tag, "_idle_result"}, 32'(result), 32'(last_result));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        len   = 5'd0;
        fill(8'd1, 8'd1);
        tick();
        tick();
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        // start held high through reset must not launch a run
        start = 1'b1;
        tick();
        chk("rst_prio_busy", 32'(busy), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        last_result = 20'd0;
        tick();

        run_check(16, 16, 20'd16, 1'b1, "ones16");
        idle_check("ones16");

        m1[0] = 8'd255;
        m2[0] = 8'd255;
        run_check(1, 1, 20'd65025, 1'b0, "len1");
        idle_check("len1");

        fill(8'd255, 8'd255);
        run_check(16, 16, 20'd1040400, 1'b0, "max16");
        run_check(0, 16, 20'd1040400, 1'b0, "len0_b2b");
        run_check(20, 16, 20'd1040400, 1'b0, "len20_b2b");
        run_check(5, 5, 20'd325125, 1'b0, "len5_b2b");
        idle_check("len5");

`ifdef MAC_SEQ_ABORT_EN
        start = 1'b1;
        len   = 5'd16;
        tick();
        start = 1'b0;
        for (int i = 1; i < 7; i++) tick();
        chk("abort_at7_cnt", 32'(cnt), 32'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_cnt", 32'(cnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'(last_result));
        chk("abort_done", 32'(done), 32'd0);
        tick();
        chk("abort_done2", 32'(done), 32'd0);
        abort = 1'b1;
`endif
        start = 1'b1;
        len   = 5'd16;
        tick();
        start = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        chk("rstrun_start_cnt", 32'(cnt), 32'd1);
        chk("rstrun_start_busy", 32'(busy), 32'd1);
        for (int i = 1; i < 7; i++) tick();
        chk("rstrun_at7_cnt", 32'(cnt), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstrun_cnt", 32'(cnt), 32'd0);
        chk("rstrun_busy", 32'(busy), 32'd0);
        chk("rstrun_result", 32'(result), 32'd0);
        chk("rstrun_done", 32'(done), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("rstrun_no_done", 32'(done), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
